// File: rtl/switch_logic_debounced_if.sv
// Switch/LED bus between the board pins and the debounced switch logic.
interface switch_logic_debounced_if #(
    parameter int NUM_SW = 2
);
    logic [NUM_SW-1:0] i_Switch;
    logic [1:0]        i_Mode;
    logic [NUM_SW-1:0] o_Switch_Db;
    logic              o_Change;
    logic              o_LED;

    // Driver side: the board pins / stimulus.
    modport master (
        output i_Switch, i_Mode,
        input  o_Switch_Db, o_Change, o_LED
    );

    // Logic side: the debouncer and LED function.
    modport slave (
        input  i_Switch, i_Mode,
        output o_Switch_Db, o_Change, o_LED
    );
endinterface

// File: rtl/switch_logic_debounced.sv
// NUM_SW raw switches -> 2-flop sync -> per-channel counter debounce ->
// runtime-selectable function (AND/OR/XOR/release-toggle) -> registered LED.
module switch_logic_debounced #(
    parameter int NUM_SW         = 2,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input logic                    i_Clk,
    input logic                    i_Rst_n,
    switch_logic_debounced_if.slave bus
);
    localparam int             CW       = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_SW-1:0] sync1, sync2;
    logic [NUM_SW-1:0] db, db_next;
    logic              change, rel, t, t_next, led;

    // Two-flop synchroniser on every raw switch line.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.i_Switch;
            sync2 <= sync1;
        end
    end

    // Independent debounce counter per channel; any return to the stable
    // level wipes the progress so a new attempt needs the full count.
    genvar g;
    generate
        for (g = 0; g < NUM_SW; g++) begin : g_ch
            logic [CW-1:0] cnt;
            logic          hit;

            assign hit        = (sync2[g] != db[g]) && (cnt == CNT_LAST);
            assign db_next[g] = hit ? sync2[g] : db[g];

            // Count consecutive cycles the synchronised level differs from stable.
            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n)
                    cnt <= '0;
                else if (sync2[g] == db[g] || hit)
                    cnt <= '0;
                else
                    cnt <= cnt + CW'(1);
            end
        end
    endgenerate

    // Toggle flips one edge after a debounced release of channel 0, only in mode 11.
    always_comb begin
        t_next = t;
        if (bus.i_Mode == 2'b11 && rel)
            t_next = ~t;
    end

    // Debounced vector, change/release pulses, toggle state and LED function.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            db     <= '0;
            change <= 1'b0;
            rel    <= 1'b0;
            t      <= 1'b0;
            led    <= 1'b0;
        end else begin
            db     <= db_next;
            change <= (db_next != db);
            rel    <= db[0] & ~db_next[0];
            t      <= t_next;
            case (bus.i_Mode)
                2'b00:   led <= &db;
                2'b01:   led <= |db;
                2'b10:   led <= ^db;
                default: led <= t_next;
            endcase
        end
    end

    assign bus.o_Switch_Db = db;
    assign bus.o_Change    = change;
    assign bus.o_LED       = led;
endmodule

// File: tb/tb_switch_logic_debounced.sv
// Bench for switch_logic_debounced: reset, table of mode/function vectors,
// glitch/toggle/reset/simultaneous corner sequences, then random stimulus
// against a history-based reference model.
module tb_switch_logic_debounced;
    localparam int NSW = 2;
    localparam int LIM = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NSW-1:0] sw = '0;
    logic [1:0]     mode = 2'b00;

    always #5 clk = ~clk;

    switch_logic_debounced_if #(.NUM_SW(NSW)) bus ();
    assign bus.i_Switch = sw;
    assign bus.i_Mode   = mode;

    switch_logic_debounced #(.NUM_SW(NSW), .DEBOUNCE_LIMIT(LIM)) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // A channel accepts a new level when the last LIM synchronised samples
    // (raw input delayed by two edges) all disagree with its stable level.
    logic [NSW-1:0] rawq[$];
    logic [NSW-1:0] sampq[$];
    logic [NSW-1:0] db_m;
    logic           chg_m, rel_m, t_m, led_m;

    task automatic model_clear();
        rawq.delete();
        sampq.delete();
        db_m = '0; chg_m = 0; rel_m = 0; t_m = 0; led_m = 0;
    endtask

    task automatic model_edge();
        logic [NSW-1:0] s, nd;
        logic           nt, all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        rawq.push_back(sw);
        if (rawq.size() > 3) void'(rawq.pop_front());
        s = (rawq.size() == 3) ? rawq[0] : '0;
        sampq.push_back(s);
        if (sampq.size() > LIM) void'(sampq.pop_front());
        nd = db_m;
        for (int b = 0; b < NSW; b++) begin
            all_diff = (sampq.size() == LIM);
            foreach (sampq[i]) if (sampq[i][b] == db_m[b]) all_diff = 0;
            if (all_diff) nd[b] = ~db_m[b];
        end
        nt = (mode == 2'b11 && rel_m) ? ~t_m : t_m;
        case (mode)
            2'b00:   led_m = (db_m == '1);
            2'b01:   led_m = (db_m != '0);
            2'b10:   led_m = ^db_m;
            default: led_m = nt;
        endcase
        chg_m = (nd != db_m);
        rel_m = db_m[0] && !nd[0];
        t_m   = nt;
        db_m  = nd;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] sw;
        logic [1:0] mode;
        logic [1:0] db;
        logic       led;
    } vec_t;

    vec_t tbl[9];
    int   pulses;
    int   hold;
    bit   seen;
    bit   bad_mix;

    initial begin
        tbl[0] = '{2'b11, 2'b10, 2'b11, 1'b0};
        tbl[1] = '{2'b11, 2'b01, 2'b11, 1'b1};
        tbl[2] = '{2'b01, 2'b01, 2'b01, 1'b1};
        tbl[3] = '{2'b01, 2'b10, 2'b01, 1'b1};
        tbl[4] = '{2'b01, 2'b00, 2'b01, 1'b0};
        tbl[5] = '{2'b10, 2'b10, 2'b10, 1'b1};
        tbl[6] = '{2'b10, 2'b00, 2'b10, 1'b0};
        tbl[7] = '{2'b11, 2'b00, 2'b11, 1'b1};
        tbl[8] = '{2'b00, 2'b01, 2'b00, 1'b0};

        // 1. Reset hold with switches high, then release and time acceptance.
        model_clear();
        sw = 2'b11; mode = 2'b00; rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            check("rst_db", 8'(bus.o_Switch_Db), 8'h0);
            check("rst_chg", 8'(bus.o_Change), 8'h0);
            check("rst_led", 8'(bus.o_LED), 8'h0);
            step();
        end
        rst_n = 1'b1;
        repeat (9) step();                       // edges 0..8
        check("acc_early_db", 8'(bus.o_Switch_Db), 8'h0);
        step();                                  // edge 9
        check("acc_db", 8'(bus.o_Switch_Db), 8'h3);
        check("acc_chg", 8'(bus.o_Change), 8'h1);
        check("acc_led_lag", 8'(bus.o_LED), 8'h0);
        step();                                  // edge 10
        check("acc_led", 8'(bus.o_LED), 8'h1);
        check("acc_chg_off", 8'(bus.o_Change), 8'h0);

        // Function table: hold each pattern long enough to debounce.
        for (int k = 0; k < 9; k++) begin
            sw = tbl[k].sw; mode = tbl[k].mode;
            repeat (12) step();
            check($sformatf("tbl%0d_db", k), 8'(bus.o_Switch_Db), 8'(tbl[k].db));
            check($sformatf("tbl%0d_led", k), 8'(bus.o_LED), 8'(tbl[k].led));
        end

        // Mode change is visible one edge after the write.
        sw = 2'b01;
        repeat (12) step();
        mode = 2'b10; step();
        check("mode_xor_1edge", 8'(bus.o_LED), 8'h1);
        mode = 2'b00; step();
        check("mode_and_1edge", 8'(bus.o_LED), 8'h0);
        sw = 2'b00;
        repeat (12) step();

        // 2. Short pulses on switch 0 never get accepted.
        seen = 0;
        for (int r = 0; r < 3; r++) begin
            sw = 2'b01; repeat (5) step();
            if (bus.o_Change || bus.o_Switch_Db != 2'b00 || bus.o_LED) seen = 1;
            sw = 2'b00; repeat (5) step();
            if (bus.o_Change || bus.o_Switch_Db != 2'b00 || bus.o_LED) seen = 1;
        end
        repeat (4) step();
        check("glitch_any_activity", 8'(seen), 8'h0);
        check("glitch_db", 8'(bus.o_Switch_Db), 8'h0);

        // 4. Toggle mode: flip on release only; held across a mode-00 excursion.
        do_reset(2);
        sw = 2'b00; mode = 2'b11;
        repeat (3) step();
        sw = 2'b01;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.o_LED) seen = 1;
        end
        check("tog_press_led", 8'(seen), 8'h0);
        check("tog_press_db", 8'(bus.o_Switch_Db), 8'h1);
        sw = 2'b00;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.o_Switch_Db[0] == 1'b0) seen = 1;
        end
        check("tog_rel_seen", 8'(seen), 8'h1);
        check("tog_rel_led_same_edge", 8'(bus.o_LED), 8'h0);
        step();
        check("tog_rel_led", 8'(bus.o_LED), 8'h1);
        // press, drop to mode 00 mid-hold, release there: t must not flip
        sw = 2'b01; repeat (12) step();
        mode = 2'b00; repeat (4) step();
        check("tog_and_led", 8'(bus.o_LED), 8'h0);
        sw = 2'b00; repeat (14) step();
        mode = 2'b11; step();
        check("tog_hold_t", 8'(bus.o_LED), 8'h1);
        // press/release in mode 11 again flips back to 0
        sw = 2'b01; repeat (14) step();
        check("tog2_press_led", 8'(bus.o_LED), 8'h1);
        sw = 2'b00; repeat (14) step();
        check("tog2_rel_led", 8'(bus.o_LED), 8'h0);

        // 5. Reset mid-count discards progress.
        sw = 2'b10; mode = 2'b01;
        repeat (12) step();
        check("midrst_pre_led", 8'(bus.o_LED), 8'h1);
        sw = 2'b11;
        repeat (7) step();                       // channel 0 count now 5
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_db", 8'(bus.o_Switch_Db), 8'h0);
        check("midrst_led", 8'(bus.o_LED), 8'h0);
        check("midrst_chg", 8'(bus.o_Change), 8'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (9) step();
        check("midrst_no_early", 8'(bus.o_Switch_Db), 8'h0);
        step();
        check("midrst_acc", 8'(bus.o_Switch_Db), 8'h3);

        // 6. Simultaneous change on both bits -> one update, one pulse.
        do_reset(2);
        sw = 2'b00; mode = 2'b00;
        repeat (3) step();
        sw = 2'b11;
        pulses = 0; bad_mix = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.o_Change) pulses++;
            if (bus.o_Switch_Db == 2'b01 || bus.o_Switch_Db == 2'b10) bad_mix = 1;
        end
        check("simul_pulses", 8'(pulses), 8'h1);
        check("simul_split", 8'(bad_mix), 8'h0);
        check("simul_db", 8'(bus.o_Switch_Db), 8'h3);

        // Random stimulus against the reference model.
        do_reset(2);
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                sw   = NSW'($urandom);
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            step();
            check("rnd_db", 8'(bus.o_Switch_Db), 8'(db_m));
            check("rnd_chg", 8'(bus.o_Change), 8'(chg_m));
            check("rnd_led", 8'(bus.o_LED), 8'(led_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
